// File: rtl/bios_arb_pkg.sv
// Shared constants and helpers for the BIOS read-port arbiter.
package bios_arb_pkg;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LD = 1'b1;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  // Right-align the addressed byte lane of a 32-bit word, zero-filling the top.
  function automatic logic [31:0] lane_shift(input logic [31:0] data, input logic [1:0] off);
    return data >> {off, 3'b000};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; rr_last_q remembers the port granted most recently.
module rr_arb2
  import bios_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_last_q;
  logic rr_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= PORT_LD;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  // On contention the port that did not win last time is granted.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (rr_last_q == PORT_LD) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (|gnt) begin
      rr_last_d = gnt[PORT_LD] ? PORT_LD : PORT_IF;
    end
  end

endmodule

// File: rtl/bios_arbiter.sv
// Shares one synchronous BIOS read port between instruction fetch (port 0)
// and data loads (port 1), steering each 1-cycle-latency response back.
module bios_arbiter
  import bios_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ready,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a request transfers in a cycle where valid and ready are both
  // high; requesters hold valid/addr until ready. Responses have no
  // back-pressure and must be taken in the cycle rvalid is high.

  logic [1:0] req;
  logic [1:0] gnt;
  logic       arb_en;

  logic       pend_vld_q, pend_vld_d;
  logic       pend_port_q, pend_port_d;
  logic [1:0] pend_off_q, pend_off_d;

  logic [1:0] unused_if_lsb;
  assign unused_if_lsb = if_addr[1:0];

  assign req    = {ld_valid, if_valid};
  assign arb_en = en & rst_n;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (req),
    .gnt   (gnt)
  );

  assign if_ready = gnt[PORT_IF];
  assign ld_ready = gnt[PORT_LD];
  assign mem_en   = |gnt;

  always_comb begin
    mem_addr = '0;
    if (gnt[PORT_IF]) begin
      mem_addr = if_addr[ADDR_W-1:2];
    end else if (gnt[PORT_LD]) begin
      mem_addr = ld_addr[ADDR_W-1:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q  <= 1'b0;
      pend_port_q <= PORT_IF;
      pend_off_q  <= 2'b00;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_port_q <= pend_port_d;
      pend_off_q  <= pend_off_d;
    end
  end

  // Fetches are word-aligned, so only loads carry a byte offset forward.
  always_comb begin
    pend_vld_d  = |gnt;
    pend_port_d = pend_port_q;
    pend_off_d  = pend_off_q;
    if (|gnt) begin
      pend_port_d = gnt[PORT_LD] ? PORT_LD : PORT_IF;
      pend_off_d  = gnt[PORT_LD] ? ld_addr[1:0] : 2'b00;
    end
  end

  assign if_rvalid = pend_vld_q & (pend_port_q == PORT_IF);
  assign ld_rvalid = pend_vld_q & (pend_port_q == PORT_LD);

  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign ld_rdata = ld_rvalid ? lane_shift(mem_rdata, pend_off_q) : '0;

endmodule

// File: tb/tb_bios_arbiter.sv
// Directed bench for bios_arbiter with a behavioural registered-read memory.
module tb_bios_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        if_valid;
  logic [11:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ld_valid;
  logic [11:0] ld_addr;
  logic        ld_ready;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  logic [33:0] exp_q[$];
  int          n_tests;
  int          n_fail;

  bios_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .if_valid  (if_valid),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_ready  (ld_ready),
    .ld_rvalid (ld_rvalid),
    .ld_rdata  (ld_rdata),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [31:0] align(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd0:    return d;
      2'd1:    return {8'h00, d[31:8]};
      2'd2:    return {16'h0000, d[31:16]};
      default: return {24'h000000, d[31:24]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the response due this cycle against the scoreboard head.
  task automatic check_resp();
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, e[33]});
    chk("ld_rvalid", {31'd0, ld_rvalid}, {31'd0, e[32]});
    chk("if_rdata", if_rdata, e[33] ? e[31:0] : 32'd0);
    chk("ld_rdata", ld_rdata, e[32] ? e[31:0] : 32'd0);
  endtask

  // One clock: drive requests, check grant and response, queue next response.
  task automatic cycle(input logic ifv, input logic [11:0] ia, input logic ldv,
                       input logic [11:0] la, input logic e,
                       input logic exp_if, input logic exp_ld);
    if_valid = ifv;
    if_addr  = ia;
    ld_valid = ldv;
    ld_addr  = la;
    en       = e;
    @(negedge clk);
    chk("if_ready", {31'd0, if_ready}, {31'd0, exp_if});
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, exp_ld});
    chk("mem_en", {31'd0, mem_en}, {31'd0, exp_if | exp_ld});
    if (exp_if) chk("mem_addr_if", {22'd0, mem_addr}, {22'd0, ia[11:2]});
    if (exp_ld) chk("mem_addr_ld", {22'd0, mem_addr}, {22'd0, la[11:2]});
    check_resp();
    if (exp_if)      exp_q.push_back({2'b10, mem[ia[11:2]]});
    else if (exp_ld) exp_q.push_back({2'b01, align(mem[la[11:2]], la[1:0])});
    else             exp_q.push_back(34'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
  endtask

  // Hold reset for one cycle with both ports requesting; everything must be quiet.
  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b1;
    if_valid = 1'b1;
    ld_valid = 1'b1;
    if_addr  = 12'h004;
    ld_addr  = 12'h008;
    @(negedge clk);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ld_rdata", ld_rdata, 32'd0);
    exp_q.delete();
    exp_q.push_back(34'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    if_valid = 1'b0;
    ld_valid = 1'b0;
    if_addr  = '0;
    ld_addr  = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[1] = 32'h11223344;
    mem[2] = 32'hAABBCCDD;

    do_reset();

    // Back-to-back fetches.
    cycle(1'b1, 12'h004, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 12'h008, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
    idle();

    // Contention from reset alternates IF, LD, IF, LD.
    do_reset();
    cycle(1'b1, 12'h004, 1'b1, 12'h00B, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 12'h008, 1'b1, 12'h00B, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 12'h008, 1'b1, 12'h009, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 12'h004, 1'b1, 12'h009, 1'b1, 1'b0, 1'b1);
    idle();

    // Same address on both ports: no merging, normal alternation.
    cycle(1'b1, 12'h008, 1'b1, 12'h008, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 12'h000, 1'b1, 12'h008, 1'b1, 1'b0, 1'b1);

    // Byte-lane alignment of loads.
    cycle(1'b0, 12'h000, 1'b1, 12'h00B, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 12'h000, 1'b1, 12'h008, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 12'h000, 1'b1, 12'h009, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 12'h000, 1'b1, 12'h00A, 1'b1, 1'b0, 1'b1);
    idle();

    // Random single-requester traffic.
    for (int i = 0; i < 12; i++) begin
      logic [11:0] a;
      a = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 0) cycle(1'b1, a, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
      else                           cycle(1'b0, 12'h000, 1'b1, a, 1'b1, 1'b0, 1'b1);
    end
    idle();

    // en drops right after a fetch grant: response still arrives, no new grants.
    cycle(1'b1, 12'h004, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 12'h008, 1'b1, 12'h009, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 12'h008, 1'b1, 12'h009, 1'b0, 1'b0, 1'b0);
    idle();

    // Reset right after a load grant drops that response; fetch wins afterwards.
    cycle(1'b0, 12'h000, 1'b1, 12'h009, 1'b1, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 12'h004, 1'b1, 12'h00A, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 12'h008, 1'b1, 12'h00A, 1'b1, 1'b0, 1'b1);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
